// File: rtl/q15_div_sequencer.sv
// q15_div_sequencer: operand FIFO plus load/launch/wait/capture sequencer in front of the Q15 divider.
// Define Q15_DIV_SEQ_TIMEOUT_EN to add the WAIT watchdog and its timeout output.
module q15_div_sequencer #(
    parameter int FIFO_DEPTH = 4
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [63:0]                 in_a,
    input  logic [63:0]                 in_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [63:0]                 out_res,
    output logic                        div_launch,
    output logic [63:0]                 div_a,
    output logic [63:0]                 div_b,
    input  logic                        div_busy,
    input  logic [63:0]                 div_res,
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
    output logic                        timeout,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t        state_q, state_d;
    logic [127:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          out_valid_q, out_valid_d, launch_q, launch_d;
    logic [63:0]   out_res_q, out_res_d, a_q, a_d, b_q, b_d;
    logic          push, pop, slot_free;
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    assign timeout = timeout_q;
`endif

    assign in_ready   = count_q != FULL;
    assign fifo_count = count_q;
    assign out_valid  = out_valid_q;
    assign out_res    = out_res_q;
    assign div_launch = launch_q;
    assign div_a      = a_q;
    assign div_b      = b_q;

    always_comb begin
        push        = in_valid && in_ready;
        pop         = 1'b0;
        slot_free   = !out_valid_q || out_ready;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        launch_d    = 1'b0;
        out_valid_d = out_valid_q && !out_ready;
        out_res_d   = out_res_q;
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (count_q != '0) begin
                pop        = 1'b1;
                {a_d, b_d} = mem_q[rd_q];
                launch_d   = 1'b1;
                state_d    = LAUNCH;
            end
            LAUNCH: begin
                state_d = WAIT;
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (!div_busy && slot_free) begin
                out_res_d   = div_res;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
            // once expired the counter holds until the output slot frees
            else if (cnt_q == TW'(TIMEOUT_CYCLES)) begin
                if (slot_free) begin
                    out_res_d   = 64'h8000_0000_0000_0000;
                    out_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end
            end
            else if (div_busy) cnt_d = cnt_q + TW'(1);
`endif
            default: state_d = IDLE;
        endcase
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {in_a, in_b};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            launch_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            launch_q    <= launch_d;
            a_q         <= a_d;
            b_q         <= b_d;
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end
endmodule

// File: tb/tb_q15_div_sequencer.sv
// tb_q15_div_sequencer: scoreboard bench with a variable-latency divider model behind the sequencer.
// Build with Q15_DIV_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_q15_div_sequencer;
    localparam logic [63:0] NAN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, div_launch, div_busy;
    logic [63:0] out_res, div_a, div_b, div_res;
    logic [2:0]  fifo_count;
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
    logic        timeout;
    int          n_to = 0;
`endif

    q15_div_sequencer #(
        .FIFO_DEPTH(4)
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .div_launch(div_launch), .div_a(div_a), .div_b(div_b),
        .div_busy(div_busy), .div_res(div_res),
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
        .timeout(timeout),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Divider model: special operands never raise busy; others stay busy for busy_len cycles.
    int busy_len = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (!reset) busy_cnt <= 0;
        else if (div_launch && div_a != 0 && div_b != 0) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign div_busy = busy_cnt != 0;
    assign div_res  = (div_b == 0) ? NAN : (div_a == 0) ? 64'd0 :
                      64'(({64'd0, div_a} << 15) / {64'd0, div_b});

    int          n_chk = 0, n_fail = 0, n_out = 0, n_launch = 0;
    logic [63:0] exp_q[$];
    int          ready_mode = 1;
    logic [63:0] va[6], vb[6], vr[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
        logic hs;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                exp_q.push_back(r);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail("send_stuck");
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    // Monitor: scoreboard pops, output hold, launch width, in_ready/full relation.
    initial begin
        logic [63:0] held;
        logic        hold_v, prev_launch;
        hold_v = 1'b0;
        prev_launch = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (hold_v) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_res", out_res, held);
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) fail("unexpected_out");
                    else chk("out_res", out_res, exp_q.pop_front());
                end
                if (div_launch) n_launch++;
                if (div_launch && prev_launch) fail("launch_width");
                chk("in_ready", 64'(in_ready), 64'(fifo_count != 3'd4));
`ifdef Q15_DIV_SEQ_TIMEOUT_EN
                if (timeout) n_to++;
`endif
            end
            hold_v = reset && out_valid && !out_ready;
            held = out_res;
            prev_launch = reset && div_launch;
        end
    end

    initial begin
        #500000;
        fail("global_watchdog");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0, o0, i;
        logic stable;
        va = '{64'h20000, 64'h0,    64'h8000, 64'hC000,  64'h8000,  64'h30000};
        vb = '{64'h10000, 64'h8000, 64'h0,    64'h4000,  64'h10000, 64'h18000};
        vr = '{64'h10000, 64'h0,    NAN,      64'h18000, 64'h4000,  64'h10000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", out_res, 64'd0);
        chk("rst_launch", 64'(div_launch), 64'd0);
        chk("rst_div_a", div_a, 64'd0);
        chk("rst_div_b", div_b, 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;

        // 4.0 / 2.0 with a 10-cycle busy divider
        busy_len = 10;
        l0 = n_launch;
        o0 = n_out;
        send(64'h20000, 64'h10000, 64'h10000);
        stable = 1'b1;
        for (i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
            if (div_a !== 64'h20000 || div_b !== 64'h10000) stable = 1'b0;
        end
        chk("t1_done", 64'(out_valid), 64'd1);
        chk("t1_operands_stable", 64'(stable), 64'd1);
        chk("t1_wait_cycles", 64'(i), 64'd12);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_launch_count", 64'(n_launch - l0), 64'd1);
        chk("t1_out_count", 64'(n_out - o0), 64'd1);

        // special operand: result appears 3 edges after acceptance
        send(64'h0, 64'h8000, 64'h0);
        @(posedge clk); #1; chk("t2_edge1", 64'(out_valid), 64'd0);
        @(posedge clk); #1; chk("t2_edge2", 64'(out_valid), 64'd0);
        @(posedge clk); #1; chk("t2_edge3", 64'(out_valid), 64'd1);
        chk("t2_res", out_res, 64'd0);
        drain("t2_drain", 20);

        // back-pressure: full FIFO, held slot, second result stalled in WAIT
        ready_mode = 0;
        busy_len = 5;
        for (int k = 0; k < 6; k++) send(va[k], vb[k], vr[k]);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_count_full", 64'(fifo_count), 64'd4);
        chk("t3_in_ready_low", 64'(in_ready), 64'd0);
        chk("t3_slot_held", 64'(out_valid), 64'd1);
        chk("t3_slot_res", out_res, vr[0]);
        chk("t3_second_in_wait", div_a, va[1]);
        ready_mode = 1;
        drain("t3_drain", 200);

        // reset while waiting with two entries queued
        busy_len = 30;
        send(va[0], vb[0], vr[0]);
        send(va[3], vb[3], vr[3]);
        send(va[4], vb[4], vr[4]);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_pre_count", 64'(fifo_count), 64'd2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        chk("t4_count", 64'(fifo_count), 64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_launch", 64'(div_launch), 64'd0);
        chk("t4_div_a", div_a, 64'd0);
        @(posedge clk);
        #1;
        chk("t4_idle", 64'(div_launch), 64'd0);
        busy_len = 3;
        send(va[3], vb[3], vr[3]);
        drain("t4_after", 50);

        // 200 pairs with random consumer back-pressure
        ready_mode = 2;
        o0 = n_out;
        for (int k = 0; k < 200; k++) begin
            busy_len = k % 4;
            send(va[k % 6], vb[k % 6], vr[k % 6]);
        end
        ready_mode = 1;
        drain("t5_drain", 3000);
        chk("t5_out_count", 64'(n_out - o0), 64'd200);

`ifdef Q15_DIV_SEQ_TIMEOUT_EN
        busy_len = 100000;
        send(va[0], vb[0], NAN);
        for (int k = 0; k < 10 && !div_busy; k++) @(posedge clk);
        #1;
        busy_len = 3;
        send(va[0], vb[0], 64'h10000);
        drain("t6_drain", 200);
        chk("t6_timeout_pulses", 64'(n_to), 64'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
